// File: rtl/shared_ram_rr_pkg.sv
// Shared definitions for the round-robin shared RAM: default geometry and the
// load/store op encoding used by the core LSUs, the RAM and the bench.
package mem_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int N_CORES_DEF = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // A single-core build still needs a 1-bit pointer register.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_ram_rr_if.sv
// Core-side request/response bus of the shared RAM, one lane per core packed
// into flat vectors; cores use the master modport, the RAM the slave modport.
interface shared_ram_rr_if import mem_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int N_CORES = N_CORES_DEF
) ();

  logic [N_CORES-1:0]        REQ;
  logic [N_CORES-1:0]        WR;
  logic [N_CORES*ADDR_W-1:0] ADDBUS;
  logic [N_CORES*DATA_W-1:0] DATAIN;
  logic [N_CORES-1:0]        GNT;
  logic [DATA_W-1:0]         DATAOUT;
  logic [N_CORES-1:0]        RVALID;

  modport master (
    output REQ, WR, ADDBUS, DATAIN,
    input  GNT, DATAOUT, RVALID
  );

  modport slave (
    input  REQ, WR, ADDBUS, DATAIN,
    output GNT, DATAOUT, RVALID
  );

endinterface

// File: rtl/shared_ram_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer, which moves to just past the winner on every granted cycle.
module rr_arbiter import mem_pkg::*; #(
  parameter int N = N_CORES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = ptr_width(N);

  logic [PTR_W-1:0] ptr_d, ptr_q;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = PTR_W'((int'(ptr_q) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_d    = PTR_W'((int'(idx) + 1) % N);
        found    = 1'b1;
      end
    end
    // Suppress grants during reset so nothing is written or read back.
    if (rst) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_ram_rr.sv
// Single-port synchronous RAM shared by N_CORES cores through a round-robin
// arbiter; reads return one cycle after grant on a shared bus tagged by RVALID.
module shared_ram_rr import mem_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int N_CORES = N_CORES_DEF
) (
  input logic            clk,
  input logic            rst,
  shared_ram_rr_if.slave bus
);

  logic [N_CORES-1:0] gnt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_wr;
  logic               sel_any;

  logic [DATA_W-1:0]  mem_q [2**ADDR_W];
  logic [DATA_W-1:0]  dataout_d, dataout_q;
  logic [N_CORES-1:0] rvalid_d, rvalid_q;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.REQ),
    .gnt (gnt)
  );

  // The grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | bus.ADDBUS[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | bus.DATAIN[i*DATA_W +: DATA_W];
        sel_wr   = sel_wr   | bus.WR[i];
      end
    end
    sel_any = |gnt;
  end

  always_comb begin
    rvalid_d  = '0;
    dataout_d = dataout_q;
    if (sel_any && (sel_wr == OP_READ)) begin
      rvalid_d  = gnt;
      dataout_d = mem_q[sel_addr];
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (sel_any && (sel_wr == OP_WRITE)) begin
      mem_q[sel_addr] <= sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= '0;
      dataout_q <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      dataout_q <= dataout_d;
    end
  end

  assign bus.GNT     = gnt;
  assign bus.RVALID  = rvalid_q;
  assign bus.DATAOUT = dataout_q;

endmodule

// File: tb/tb_shared_ram_rr.sv
// Bench for shared_ram_rr: directed vector table, hand-written corner sequences
// and randomized traffic checked against a rotating-priority / array RAM model.
module tb_shared_ram_rr;
  import mem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  shared_ram_rr_if #(.DATA_W(DW), .ADDR_W(AW), .N_CORES(NC)) bus ();

  shared_ram_rr #(.DATA_W(DW), .ADDR_W(AW), .N_CORES(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [15:0] dout;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_mem [int];
  int          m_ptr;
  int          m_idx;
  logic [3:0]  m_rvalid;
  logic [15:0] m_dout;
  bit          m_known;
  logic [3:0]  l_req, l_wr;
  logic [63:0] l_addr, l_data;

  function automatic vec_t mk(bit rb, logic [3:0] req, logic [3:0] wr,
                              logic [63:0] addr, logic [63:0] data,
                              logic [3:0] gnt, logic [3:0] rv, logic [15:0] dout);
    vec_t v;
    v.rst_before = rb; v.req = req; v.wr = wr; v.addr = addr; v.data = data;
    v.gnt = gnt; v.rvalid = rv; v.dout = dout;
    return v;
  endfunction

  function automatic void model_reset();
    m_ptr    = 0;
    m_rvalid = '0;
    m_dout   = '0;
    m_known  = 1'b1;
  endfunction

  // Winner is the requester with the smallest forward distance from the pointer.
  function automatic int model_pick(logic [3:0] req);
    int best = -1;
    int bestd = NC;
    for (int i = 0; i < NC; i++) begin
      if (req[i]) begin
        int d = (i - m_ptr + NC) % NC;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] model_gnt();
    return (m_idx >= 0) ? 4'(1 << m_idx) : 4'b0000;
  endfunction

  function automatic void model_commit();
    logic [15:0] a;
    m_rvalid = '0;
    if (m_idx >= 0) begin
      a = l_addr[m_idx*16 +: 16];
      if (l_wr[m_idx] == OP_WRITE) begin
        m_mem[int'(a)] = l_data[m_idx*16 +: 16];
      end else begin
        m_rvalid = 4'(1 << m_idx);
        if (m_mem.exists(int'(a))) begin
          m_dout  = m_mem[int'(a)];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
      m_ptr = (m_idx + 1) % NC;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.REQ = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive at the falling edge; outputs are sampled 1 time unit later, so GNT
  // reflects this cycle and RVALID/DATAOUT reflect the previous cycle's grant.
  task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] wr,
                                input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.REQ = req; bus.WR = wr; bus.ADDBUS = addr; bus.DATAIN = data;
    l_req = req; l_wr = wr; l_addr = addr; l_data = data;
    m_idx = model_pick(req);
    #1;
  endtask

  task automatic check_output(input string name, input logic [3:0] eg,
                              input logic [3:0] erv, input logic [15:0] ed,
                              input bit dchk);
    bit bad = 1'b0;
    vectors++;
    if (bus.GNT !== eg) begin
      $display("[TB] FAIL %s GNT got %b expected %b @%0t", name, bus.GNT, eg, $time);
      bad = 1'b1;
    end
    if (bus.RVALID !== erv) begin
      $display("[TB] FAIL %s RVALID got %b expected %b @%0t", name, bus.RVALID, erv, $time);
      bad = 1'b1;
    end
    if (dchk && (bus.DATAOUT !== ed)) begin
      $display("[TB] FAIL %s DATAOUT got %h expected %h @%0t", name, bus.DATAOUT, ed, $time);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  task automatic step(input string name, input logic [3:0] req, input logic [3:0] wr,
                      input logic [63:0] addr, input logic [63:0] data,
                      input logic [3:0] eg, input logic [3:0] erv, input logic [15:0] ed);
    apply_stimulus(req, wr, addr, data);
    check_output(name, eg, erv, ed, 1'b1);
    model_commit();
  endtask

  vec_t tbl[$];
  logic [15:0] pool [12];

  initial begin
    bus.REQ = '0; bus.WR = '0; bus.ADDBUS = '0; bus.DATAIN = '0;
    l_req = '0; l_wr = '0; l_addr = '0; l_data = '0; m_idx = -1;
    model_reset();

    // Single core, address extremes, preload per-core data, all-core fairness
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 64'h0000, 64'h00FF, 4'b0001, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 64'h0001, 64'hFF00, 4'b0001, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 64'h0001, 64'h0,    4'b0001, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 64'h0000, 64'h0,    4'b0001, 4'b0001, 16'hFF00));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 64'hFFFF, 64'h00FF, 4'b0001, 4'b0001, 16'h00FF));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 64'hFFFE, 64'hFF00, 4'b0001, 4'b0000, 16'h00FF));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 64'hFFFF, 64'h0,    4'b0001, 4'b0000, 16'h00FF));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 64'hFFFE, 64'h0,    4'b0001, 4'b0001, 16'h00FF));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 64'h0,    64'h0,    4'b0000, 4'b0001, 16'hFF00));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0101, 16'h0}, {16'h0, 16'h0, 16'hC001, 16'h0},
                     4'b0010, 4'b0000, 16'hFF00));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, {16'h0, 16'h0102, 16'h0, 16'h0}, {16'h0, 16'hC002, 16'h0, 16'h0},
                     4'b0100, 4'b0000, 16'hFF00));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, {16'h0103, 16'h0, 16'h0, 16'h0}, {16'hC003, 16'h0, 16'h0, 16'h0},
                     4'b1000, 4'b0000, 16'hFF00));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 64'h0100, 64'hC000, 4'b0001, 4'b0000, 16'hFF00));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'h0,
                     4'b0001, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'h0,
                     4'b0010, 4'b0001, 16'hC000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'h0,
                     4'b0100, 4'b0010, 16'hC001));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'h0,
                     4'b1000, 4'b0100, 16'hC002));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'h0,
                     4'b0001, 4'b1000, 16'hC003));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 64'h0, 4'b0000, 4'b0001, 16'hC000));

    // Reset state
    @(negedge clk);
    #1;
    check_output("reset", 4'b0000, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].data,
           tbl[i].gnt, tbl[i].rvalid, tbl[i].dout);
    end

    // Pointer wrap: move pointer to 2, then REQ=0011 wraps to core0, then core1
    step("wrap_a", 4'b0010, 4'b0000, {16'h0, 16'h0, 16'h0101, 16'h0}, 64'h0, 4'b0010, 4'b0000, 16'hC000);
    step("wrap_b", 4'b0011, 4'b0000, {16'h0, 16'h0, 16'h0101, 16'h0100}, 64'h0, 4'b0001, 4'b0010, 16'hC001);
    step("wrap_c", 4'b0011, 4'b0000, {16'h0, 16'h0, 16'h0101, 16'h0100}, 64'h0, 4'b0010, 4'b0001, 16'hC000);

    // Write by core1 followed immediately by read of same address by core2
    step("raw_w", 4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0010, 16'h0}, {16'h0, 16'h0, 16'hBEEF, 16'h0},
         4'b0010, 4'b0010, 16'hC001);
    step("raw_r", 4'b0100, 4'b0000, {16'h0, 16'h0010, 16'h0, 16'h0}, 64'h0, 4'b0100, 4'b0000, 16'hC001);
    step("raw_v", 4'b0000, 4'b0000, 64'h0, 64'h0, 4'b0000, 4'b0100, 16'hBEEF);

    // Asynchronous reset in the middle of a granted read
    step("arst_a", 4'b0001, 4'b0000, 64'h0010, 64'h0, 4'b0001, 4'b0000, 16'hBEEF);
    apply_stimulus(4'b0100, 4'b0000, {16'h0, 16'h0102, 16'h0, 16'h0}, 64'h0);
    check_output("arst_b", 4'b0100, 4'b0001, 16'hBEEF, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_now", 4'b0000, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    #1;
    check_output("arst_hold", 4'b0000, 4'b0000, 16'h0000, 1'b1);
    bus.REQ = '0;
    rst = 1'b0;
    model_reset();
    step("arst_c", 4'b1010, 4'b0000, {16'h0103, 16'h0, 16'h0010, 16'h0}, 64'h0, 4'b0010, 4'b0000, 16'h0000);
    step("arst_d", 4'b1010, 4'b0000, {16'h0103, 16'h0, 16'h0010, 16'h0}, 64'h0, 4'b1000, 4'b0010, 16'hBEEF);
    step("arst_e", 4'b0000, 4'b0000, 64'h0, 64'h0, 4'b0000, 4'b1000, 16'hC003);

    // Randomized traffic against the reference model
    pool = '{16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0010, 16'h0100,
             16'h0101, 16'h0102, 16'h0103, 16'h1234, 16'h8000, 16'h7FFF};
    for (int n = 0; n < 400; n++) begin
      logic [63:0] ra, rd;
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int c = 0; c < NC; c++) begin
        ra[c*16 +: 16] = pool[$urandom_range(0, 11)];
        rd[c*16 +: 16] = 16'($urandom);
      end
      apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rd);
      check_output("rand", model_gnt(), m_rvalid, m_dout, m_known);
      model_commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
